fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction decoder. Reads 16-bit instructions as two consecutive bytes from a byte-wide, variable-latency memory port, assembles them, and buffers them in a small queue. The decoder drains the queue through a valid/ready handshake. A one-cycle redirect input reloads the PC and flushes all buffered and in-flight instructions.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 46 ++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    DRAIN    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO with flush; head is read straight from registers.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd, wr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= wdata;
        wr      <= nxt(wr);
      end
      if (pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd];
endmodule

// File: rtl/fetch_unit.sv
// Byte-wide instruction fetch: assembles big-endian 16-bit instructions into a queue.
// Optional FETCH_PERF_CNT_EN adds the stall_cycles starvation counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BYTE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc, drain_addr;
  logic [BYTE_W-1:0] hi;
  logic [CW-1:0]     count;
  logic              req_int, push, pop, ack;
  entry_t            wentry, head;

  // Request is gated by reset so mem_req reads 0 while reset is held.
  always_comb begin
    req_int  = 1'b0;
    mem_addr = pc;
    case (state)
      FETCH_HI: req_int = (count != CW'(DEPTH));
      FETCH_LO: begin
        req_int  = 1'b1;
        mem_addr = pc + ADDR_W'(1);
      end
      DRAIN: begin
        req_int  = 1'b1;
        mem_addr = drain_addr;
      end
      default: req_int = 1'b0;
    endcase
    mem_req = req_int & reset_n;
  end

  assign ack  = mem_req & mem_ack;
  assign push = (state == FETCH_LO) && ack && !redirect_valid;
  assign pop  = instr_valid & instr_ready;

  assign wentry.instr = {hi, mem_rdata};
  assign wentry.pc    = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH_HI;
      pc         <= '0;
      hi         <= '0;
      drain_addr <= '0;
    end else if (redirect_valid) begin
      // An outstanding request must still complete; its byte is thrown away.
      pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
      if (mem_req && !mem_ack) begin
        state      <= DRAIN;
        drain_addr <= mem_addr;
      end else begin
        state <= FETCH_HI;
      end
    end else begin
      case (state)
        FETCH_HI: if (ack) begin
          hi    <= mem_rdata;
          state <= FETCH_LO;
        end
        FETCH_LO: if (ack) begin
          pc    <= pc + ADDR_W'(2);
          state <= FETCH_HI;
        end
        DRAIN: if (ack) state <= FETCH_HI;
        default: state <= FETCH_HI;
      endcase
    end
  end

  fetch_queue #(.DEPTH(DEPTH), .W($bits(entry_t))) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (wentry),
    .pop     (pop),
    .flush   (redirect_valid),
    .rdata   (head),
    .count   (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cycles <= '0;
    else if (instr_ready && !instr_valid && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: instruction-stream model plus memory responder.
module tb_fetch_unit;
  logic        clk, reset_n;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        instr_valid, instr_ready;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic [15:0] stall_cycles;

  fetch_unit #(.ADDR_W(8), .DEPTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

`ifndef FETCH_PERF_CNT_EN
  assign stall_cycles = 16'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem_img [256];
  int         vectors = 0, errs = 0;
  // Stream model: the next instruction the decoder must see is at exp_pc.
  logic [7:0] exp_pc;
  bit         flush_pending, req_open;
  int         wait_cnt, cur_lat, lat_fixed, acks;
  logic [7:0] req_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    reset_n = 1'b0;
    mem_ack = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h0;
    exp_pc = 8'h0;
    flush_pending = 0;
    req_open = 0;
    acks = 0;
    lat_fixed = lat;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_stall", stall_cycles, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  // One cycle: drive inputs and memory response at negedge, then score what
  // the coming rising edge will commit.
  task automatic step(input bit rdy, input bit redir, input logic [7:0] rpc);
    @(negedge clk);
    instr_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    if (mem_req) begin
      if (!req_open) begin
        req_open = 1;
        wait_cnt = 0;
        cur_lat  = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
        req_addr = mem_addr;
      end else begin
        chk("addr_hold", mem_addr, req_addr);
      end
      if (wait_cnt >= cur_lat) begin
        mem_ack = 1'b1;
        mem_rdata = mem_img[mem_addr];
        req_open = 0;
        acks++;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
      end
      wait_cnt++;
    end else begin
      if (req_open) begin
        chk("req_held", mem_req, 1);
        req_open = 0;
      end
      mem_ack = 1'b0;
    end
    #1;
    if (flush_pending) chk("flush", instr_valid, 0);
    flush_pending = redir;
    if (instr_valid && rdy) begin
      chk("pop_pc", instr_pc, exp_pc);
      chk("pop_instr", instr, {mem_img[exp_pc], mem_img[exp_pc + 8'd1]});
      exp_pc = exp_pc + 8'd2;
    end
    if (redir) exp_pc = rpc & 8'hFE;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
    mem_img[0] = 8'h12; mem_img[1] = 8'h34; mem_img[2] = 8'h56; mem_img[3] = 8'h78;
    reset_n = 1'b0;
    mem_rdata = 8'h0;

    // Zero-wait stream from reset.
    do_reset(0);
    step(1, 0, 0); chk("t1_req0", mem_req, 1); chk("t1_addr0", mem_addr, 8'h00);
    step(1, 0, 0); chk("t1_addr1", mem_addr, 8'h01);
    step(1, 0, 0); chk("t1_valid2", instr_valid, 1); chk("t1_instr2", instr, 16'h1234);
    step(1, 0, 0); chk("t1_valid3", instr_valid, 0);
    step(1, 0, 0); chk("t1_instr4", instr, 16'h5678); chk("t1_pc4", instr_pc, 8'h02);

    // Backpressure fills the queue, then one pop restarts fetch at 0x04.
    do_reset(0);
    repeat (8) step(0, 0, 0);
    chk("t2_acks", acks, 4);
    chk("t2_idle", mem_req, 0);
    step(1, 0, 0);
    step(0, 0, 0); chk("t2_req", mem_req, 1); chk("t2_addr", mem_addr, 8'h04);

    // Redirect while a slow hi fetch is outstanding.
    do_reset(3);
    step(0, 0, 0);
    step(0, 1, 8'h41);
    step(0, 0, 0); chk("t3_hold", mem_addr, 8'h00); chk("t3_empty", instr_valid, 0);
    step(0, 0, 0); chk("t3_hold2", mem_addr, 8'h00); chk("t3_ack", mem_ack, 1);
    step(0, 0, 0); chk("t3_new", mem_addr, 8'h40); chk("t3_empty2", instr_valid, 0);
    lat_fixed = 0;
    repeat (8) step(1, 0, 0);

    // PC wrap from 0xFE.
    do_reset(0);
    step(1, 1, 8'hFE);
    step(1, 0, 0); chk("t4_fe", mem_addr, 8'hFE);
    step(1, 0, 0);
    step(1, 0, 0); chk("t4_pc", instr_pc, 8'hFE); chk("t4_wrap", mem_addr, 8'h00);
    repeat (4) step(1, 0, 0);

    // Redirect coinciding with a decoder transfer.
    do_reset(0);
    step(0, 1, 8'h10);
    repeat (6) step(0, 0, 0);
    step(1, 1, 8'h80); chk("t5_pc", instr_pc, 8'h10);
    repeat (8) step(1, 0, 0);

`ifdef FETCH_PERF_CNT_EN
    do_reset(3);
    repeat (5) step(1, 0, 0);
    step(0, 0, 0); chk("t6_stall", stall_cycles, 5);
    step(0, 1, 8'h20);
    step(0, 0, 0); chk("t6_keep", stall_cycles, 5);
`endif

    // Random traffic with a mid-run reset.
    do_reset(-1);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(-1);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
